// File: rtl/axi_led_gpio_pkg.sv
// Shared definitions for the AXI4-Lite LED/GPIO controller: register offsets,
// response codes, channel FSM states and the byte-strobe mask helper.
package axi_led_gpio_pkg;

    localparam logic [7:0] OFF_DATA      = 8'h00;
    localparam logic [7:0] OFF_BLINK_EN  = 8'h04;
    localparam logic [7:0] OFF_BLINK_DIV = 8'h08;
    localparam logic [7:0] OFF_SET       = 8'h0C;
    localparam logic [7:0] OFF_CLR       = 8'h10;
    localparam logic [7:0] OFF_ID        = 8'h14;
    localparam logic [7:0] OFF_SCRATCH   = 8'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        byte_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/axi_led_gpio_ctrl_blink.sv
// Blink phase generator: counts 0..div-1 and toggles the phase on each wrap.
module led_blink_gen
    import axi_led_gpio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] div,
    input  logic        div_wr,
    output logic        phase
);

    logic [31:0] cnt_r;
    logic        phase_r;

    // Counter and phase; a zero divider parks the phase high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= 32'd0;
            phase_r <= 1'b1;
        end else if (div_wr || (div == 32'd0)) begin
            cnt_r   <= 32'd0;
            phase_r <= 1'b1;
        end else if (cnt_r >= (div - 32'd1)) begin
            cnt_r   <= 32'd0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + 32'd1;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/axi_led_gpio_ctrl.sv
// AXI4-Lite slave with DATA/BLINK/SET/CLR/ID/SCRATCH registers driving a
// parametrised LED bank with per-bit blink.
module axi_led_gpio_ctrl
    import axi_led_gpio_pkg::*;
#(
    parameter int          NUM_LEDS      = 8,
    parameter int          ADDR_WIDTH    = 12,
    parameter logic [31:0] BLINK_DIV_RST = 32'd25_000_000,
    parameter logic [15:0] ID_VALUE      = 16'hB1ED
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [NUM_LEDS-1:0]   led_o
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    wr_state_e wr_state_r, wr_state_s;
    rd_state_e rd_state_r, rd_state_s;

    logic                  awready_r, wready_r, bvalid_r, aw_got_r, w_got_r;
    logic [1:0]            bresp_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [31:0]           w_data_r;
    logic [3:0]            w_strb_r;
    logic                  arready_r, rvalid_r;
    logic [1:0]            rresp_r;
    logic [31:0]           rdata_r;

    logic [NUM_LEDS-1:0]   data_r, blink_en_r, led_r;
    logic [31:0]           blink_div_r, scratch_r;
    logic                  phase_s;

    logic                  aw_hs_s, w_hs_s, have_aw_s, have_w_s, wr_fire_s, wr_ok_s;
    logic                  ar_hs_s, rd_ok_s, div_wr_s;
    logic [ADDR_WIDTH-1:0] wr_word_s, rd_word_s;
    logic [31:0]           wr_data_s, wr_mask_s, wr_bits_s, rd_data_s;

    // Write channel: merge held and live beats, decode target.
    always_comb begin
        aw_hs_s   = s_axi_awvalid & awready_r;
        w_hs_s    = s_axi_wvalid & wready_r;
        have_aw_s = aw_got_r | aw_hs_s;
        have_w_s  = w_got_r | w_hs_s;
        wr_word_s = (aw_got_r ? aw_addr_r : s_axi_awaddr) & WORD_MASK;
        wr_data_s = w_got_r ? w_data_r : s_axi_wdata;
        wr_mask_s = byte_mask(w_got_r ? w_strb_r : s_axi_wstrb);
        wr_bits_s = wr_data_s & wr_mask_s;
        wr_fire_s = 1'b0;
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (have_aw_s && have_w_s) begin
                    wr_fire_s  = 1'b1;
                    wr_state_s = W_RESP;
                end else begin
                    wr_state_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_s = W_IDLE;
                end else begin
                    wr_state_s = W_RESP;
                end
            end
            default: wr_state_s = W_IDLE;
        endcase
        case (wr_word_s)
            ADDR_WIDTH'(OFF_DATA), ADDR_WIDTH'(OFF_BLINK_EN), ADDR_WIDTH'(OFF_BLINK_DIV),
            ADDR_WIDTH'(OFF_SET), ADDR_WIDTH'(OFF_CLR), ADDR_WIDTH'(OFF_SCRATCH):
                wr_ok_s = 1'b1;
            default: wr_ok_s = 1'b0;
        endcase
        div_wr_s = wr_fire_s & (wr_word_s == ADDR_WIDTH'(OFF_BLINK_DIV));
    end

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state_r <= W_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write handshake bookkeeping and response.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            aw_addr_r <= '0;
            w_data_r  <= 32'd0;
            w_strb_r  <= 4'd0;
        end else if (wr_fire_s) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (wr_state_r == W_IDLE) begin
            if (aw_hs_s) begin
                aw_addr_r <= s_axi_awaddr;
                aw_got_r  <= 1'b1;
            end
            if (w_hs_s) begin
                w_data_r <= s_axi_wdata;
                w_strb_r <= s_axi_wstrb;
                w_got_r  <= 1'b1;
            end
            awready_r <= ~have_aw_s;
            wready_r  <= ~have_w_s;
        end else if (s_axi_bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
        end
    end

    // Register file; unmapped and ID writes leave state untouched.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            data_r      <= '0;
            blink_en_r  <= '0;
            blink_div_r <= BLINK_DIV_RST;
            scratch_r   <= 32'd0;
        end else if (wr_fire_s) begin
            case (wr_word_s)
                ADDR_WIDTH'(OFF_DATA):
                    data_r <= (data_r & ~wr_mask_s[NUM_LEDS-1:0]) | wr_bits_s[NUM_LEDS-1:0];
                ADDR_WIDTH'(OFF_BLINK_EN):
                    blink_en_r <= (blink_en_r & ~wr_mask_s[NUM_LEDS-1:0]) | wr_bits_s[NUM_LEDS-1:0];
                ADDR_WIDTH'(OFF_BLINK_DIV):
                    blink_div_r <= (blink_div_r & ~wr_mask_s) | wr_bits_s;
                ADDR_WIDTH'(OFF_SET):
                    data_r <= data_r | wr_bits_s[NUM_LEDS-1:0];
                ADDR_WIDTH'(OFF_CLR):
                    data_r <= data_r & ~wr_bits_s[NUM_LEDS-1:0];
                ADDR_WIDTH'(OFF_SCRATCH):
                    scratch_r <= (scratch_r & ~wr_mask_s) | wr_bits_s;
                default: ;
            endcase
        end
    end

    // Read channel next state and data mux (sees pre-write register values).
    always_comb begin
        ar_hs_s   = s_axi_arvalid & arready_r;
        rd_word_s = s_axi_araddr & WORD_MASK;
        rd_data_s = 32'd0;
        rd_ok_s   = 1'b1;
        case (rd_word_s)
            ADDR_WIDTH'(OFF_DATA):      rd_data_s = 32'(data_r);
            ADDR_WIDTH'(OFF_BLINK_EN):  rd_data_s = 32'(blink_en_r);
            ADDR_WIDTH'(OFF_BLINK_DIV): rd_data_s = blink_div_r;
            ADDR_WIDTH'(OFF_SET):       rd_data_s = 32'd0;
            ADDR_WIDTH'(OFF_CLR):       rd_data_s = 32'd0;
            ADDR_WIDTH'(OFF_ID):        rd_data_s = {ID_VALUE, 8'h00, 8'(NUM_LEDS)};
            ADDR_WIDTH'(OFF_SCRATCH):   rd_data_s = scratch_r;
            default:                    rd_ok_s   = 1'b0;
        endcase
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = R_DATA;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_DATA;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read handshake and registered response.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= 32'd0;
        end else if (rd_state_r == R_IDLE) begin
            if (ar_hs_s) begin
                arready_r <= 1'b0;
                rvalid_r  <= 1'b1;
                rdata_r   <= rd_data_s;
                rresp_r   <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                arready_r <= 1'b1;
            end
        end else if (s_axi_rready) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
        end
    end

    led_blink_gen u_blink (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .div    (blink_div_r),
        .div_wr (div_wr_s),
        .phase  (phase_s)
    );

    // LED drive: blinking bits gated by the phase.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            led_r <= '0;
        end else begin
            led_r <= (data_r & ~blink_en_r) | (data_r & blink_en_r & {NUM_LEDS{phase_s}});
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;
    assign led_o         = led_r;

endmodule

// File: tb/tb_axi_led_gpio_ctrl.sv
// Directed, table-driven bench for axi_led_gpio_ctrl with NUM_LEDS = 8.
module tb_axi_led_gpio_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [11:0] awaddr = 12'h0, araddr = 12'h0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  led;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axi_led_gpio_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .led_o(led)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw_w(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_pend = 1'b1, w_pend = 1'b1, aw_rdy, w_rdy;
        int n = 0;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_rdy = awready;
            w_rdy  = wready;
            tick();
            if (aw_rdy && aw_pend) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_rdy && w_pend)   begin wvalid = 1'b0;  w_pend = 1'b0;  end
            n++;
        end
        if (aw_pend || w_pend) chk("aw_w_timeout", 32'd1, 32'd0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic collect_b(output logic [1:0] resp);
        int n = 0;
        resp = 2'b11;
        bready = 1'b1;
        while (n < 20) begin
            if (bvalid) begin
                resp = bresp;
                tick();
                break;
            end
            tick();
            n++;
        end
        if (n == 20) chk("b_timeout", 32'd1, 32'd0);
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        send_aw_w(a, d, s);
        collect_b(resp);
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        d = 32'hX; resp = 2'b11;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        if (n == 20) chk("ar_timeout", 32'd1, 32'd0);
        rready = 1'b1;
        n = 0;
        while (n < 20) begin
            if (rvalid) begin
                d = rdata; resp = rresp;
                tick();
                break;
            end
            tick();
            n++;
        end
        if (n == 20) chk("r_timeout", 32'd1, 32'd0);
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [7:0]  led;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic        v;
        bit          found;

        vecs[0]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF, 2'b00, 8'hFF};
        vecs[1]  = '{1'b0, 12'h000, 32'h0000_00FF, 4'hF, 2'b00, 8'hFF};
        vecs[2]  = '{1'b1, 12'h018, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'hFF};
        vecs[3]  = '{1'b0, 12'h018, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'hFF};
        vecs[4]  = '{1'b1, 12'h018, 32'h0000_0011, 4'h1, 2'b00, 8'hFF};
        vecs[5]  = '{1'b0, 12'h018, 32'hDEAD_BE11, 4'hF, 2'b00, 8'hFF};
        vecs[6]  = '{1'b1, 12'h000, 32'h0000_000F, 4'hF, 2'b00, 8'h0F};
        vecs[7]  = '{1'b1, 12'h00C, 32'h0000_00F0, 4'hF, 2'b00, 8'hFF};
        vecs[8]  = '{1'b1, 12'h010, 32'h0000_0003, 4'hF, 2'b00, 8'hFC};
        vecs[9]  = '{1'b0, 12'h000, 32'h0000_00FC, 4'hF, 2'b00, 8'hFC};
        vecs[10] = '{1'b0, 12'h014, 32'hB1ED_0008, 4'hF, 2'b00, 8'hFC};
        vecs[11] = '{1'b1, 12'h014, 32'h1234_5678, 4'hF, 2'b10, 8'hFC};
        vecs[12] = '{1'b0, 12'h014, 32'hB1ED_0008, 4'hF, 2'b00, 8'hFC};
        vecs[13] = '{1'b0, 12'h040, 32'h0000_0000, 4'hF, 2'b10, 8'hFC};
        vecs[14] = '{1'b1, 12'h000, 32'h0000_0000, 4'h2, 2'b00, 8'hFC};
        vecs[15] = '{1'b0, 12'h00C, 32'h0000_0000, 4'hF, 2'b00, 8'hFC};
        vecs[16] = '{1'b1, 12'h004, 32'hFFFF_FF00, 4'hF, 2'b00, 8'hFC};
        vecs[17] = '{1'b0, 12'h004, 32'h0000_0000, 4'hF, 2'b00, 8'hFC};
        vecs[18] = '{1'b0, 12'h008, 32'h017D_7840, 4'hF, 2'b00, 8'hFC};
        vecs[19] = '{1'b0, 12'h01B, 32'hDEAD_BE11, 4'hF, 2'b00, 8'hFC};

        repeat (3) tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        ARESETn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
            end else begin
                do_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
            end
            chk($sformatf("vec%0d_resp", i), 32'(rsp), 32'(vecs[i].resp));
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
        end

        // Blink with a half-period of 4 cycles on bit 0.
        do_write(12'h008, 32'd4, 4'hF, rsp);
        do_write(12'h004, 32'h1, 4'hF, rsp);
        do_write(12'h000, 32'h1, 4'hF, rsp);
        v = led[0];
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            tick();
            if (led[0] !== v) found = 1'b1;
        end
        chk("blink_toggle_seen", 32'(found), 32'd1);
        v = led[0];
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("blink_k%0d", k), 32'(led[0]), 32'(v ^ logic'((k / 4) % 2)));
        end
        do_write(12'h008, 32'd0, 4'hF, rsp);
        for (int k = 0; k < 5; k++) begin
            chk("div0_steady", 32'(led), 32'h01);
            tick();
        end

        // AW three cycles ahead of W, then bready withheld for five cycles.
        awaddr = 12'h000; awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) tick();
        tick();
        awvalid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            chk("aw_first_awready", 32'(awready), 32'd0);
            chk("aw_first_wready", 32'(wready), 32'd1);
            tick();
        end
        wdata = 32'h0000_005A; wstrb = 4'hF; wvalid = 1'b1;
        for (int n = 0; n < 20 && !wready; n++) tick();
        tick();
        wvalid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            chk("bvalid_held", 32'(bvalid), 32'd1);
            chk("resp_awready_low", 32'(awready), 32'd0);
            tick();
        end
        chk("late_w_led", 32'(led), 32'h5A);
        chk("late_w_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
        do_read(12'h000, rd, rsp);
        chk("single_update", rd, 32'h0000_005A);

        // Reset while a write response is pending.
        send_aw_w(12'h018, 32'h0000_FEED, 4'hF);
        chk("pend_bvalid", 32'(bvalid), 32'd1);
        ARESETn = 1'b0;
        tick();
        chk("rst_mid_bvalid", 32'(bvalid), 32'd0);
        chk("rst_mid_led", 32'(led), 32'd0);
        ARESETn = 1'b1;
        repeat (2) tick();
        do_read(12'h018, rd, rsp);
        chk("post_rst_scratch", rd, 32'd0);
        do_read(12'h008, rd, rsp);
        chk("post_rst_div", rd, 32'h017D_7840);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
